// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one single-port synchronous SRAM (1-cycle read latency).
// Fixed A priority with a bounded burst limit for B, or round-robin.
module ram_arbiter #(
    parameter int WIDTH      = 8,
    parameter int ADDR_BITS  = 11,
    parameter int PRIORITY_A = 1,
    parameter int MAX_BURST  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [ADDR_BITS-1:0] a_addr,
    input  logic [WIDTH-1:0]     a_wdata,
    output logic                 a_ack,
    output logic                 a_rvalid,
    output logic [WIDTH-1:0]     a_rdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [ADDR_BITS-1:0] b_addr,
    input  logic [WIDTH-1:0]     b_wdata,
    output logic                 b_ack,
    output logic                 b_rvalid,
    output logic [WIDTH-1:0]     b_rdata,
    output logic [ADDR_BITS-1:0] ram_address,
    output logic                 ram_wren,
    output logic [WIDTH-1:0]     ram_write_data,
    input  logic [WIDTH-1:0]     ram_read_data
);

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    logic [7:0] burst_cnt;
    logic       last_b;
    logic       grant_a;
    logic       grant_b;
    logic       a_rd_pend;
    logic       b_rd_pend;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
            if (a_req && b_req) begin
                if (PRIORITY_A != 0) begin
                    if (burst_cnt < BURST_LIMIT) grant_a = 1'b1;
                    else                         grant_b = 1'b1;
                end else begin
                    if (last_b) grant_a = 1'b1;
                    else        grant_b = 1'b1;
                end
            end else begin
                grant_a = a_req;
                grant_b = b_req;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            burst_cnt <= 8'd0;
            last_b    <= 1'b1;
            a_rd_pend <= 1'b0;
            b_rd_pend <= 1'b0;
        end else begin
            a_rd_pend <= grant_a & ~a_we;
            b_rd_pend <= grant_b & ~b_we;
            if (grant_a) last_b <= 1'b0;
            if (grant_b) last_b <= 1'b1;
            if (grant_b)
                burst_cnt <= 8'd0;
            else if (grant_a && b_req && burst_cnt < BURST_LIMIT)
                burst_cnt <= burst_cnt + 8'd1;
        end
    end

    assign a_ack          = grant_a;
    assign b_ack          = grant_b;
    assign ram_address    = grant_b ? b_addr : a_addr;
    assign ram_write_data = grant_b ? b_wdata : a_wdata;
    assign ram_wren       = (grant_a & a_we) | (grant_b & b_we);

    // rvalid is masked during reset so a read granted just before reset is dropped
    assign a_rvalid = a_rd_pend & ~reset;
    assign b_rvalid = b_rd_pend & ~reset;
    assign a_rdata  = ram_read_data;
    assign b_rdata  = ram_read_data;

endmodule
